// File: rtl/fib_uart_reporter.sv
// Reports each Fibonacci result as unsigned ASCII decimal plus CR LF on an 8N1 UART line.
// Conversion uses double dabble, one bit per cycle, and then frames are sent back-to-back.
module fib_uart_reporter #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       result_valid,
  input  logic [7:0] result,
  output logic       ready,
  output logic       tx,
  output logic       dropped
);

  // Handshake: a result is taken at a rising edge when result_valid && ready.
  // A result_valid while ready is low is discarded and sets the sticky dropped flag.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SEND    = 2'd2
  } state_t;

  localparam logic [9:0] BAUD_MAX = 10'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [9:0]  baud_cnt;
  logic [3:0]  bit_idx;
  logic [2:0]  char_idx;
  logic [2:0]  conv_cnt;
  logic        last_frame;
  logic [19:0] dd;

  logic [19:0] dd_adj;
  logic [19:0] dd_next;
  logic [2:0]  first_idx;
  logic [7:0]  cur_char;
  logic        frame_bit;

  // dd = {hundreds, tens, ones, binary}; hundreds never reaches 5 for 8-bit input.
  always_comb begin
    dd_adj = dd;
    if (dd_adj[11:8] >= 4'd5)  dd_adj[11:8]  = dd_adj[11:8] + 4'd3;
    if (dd_adj[15:12] >= 4'd5) dd_adj[15:12] = dd_adj[15:12] + 4'd3;
    dd_next = {dd_adj[18:0], 1'b0};
  end

  // Character slots 0..4 are hundreds, tens, ones, CR, LF; leading zeros skip slots.
  always_comb begin
    first_idx = 3'd2;
    if (dd_next[19:16] != 4'd0)      first_idx = 3'd0;
    else if (dd_next[15:12] != 4'd0) first_idx = 3'd1;
  end

  always_comb begin
    cur_char = 8'h0A;
    case (char_idx)
      3'd0:    cur_char = {4'h3, dd[19:16]};
      3'd1:    cur_char = {4'h3, dd[15:12]};
      3'd2:    cur_char = {4'h3, dd[11:8]};
      3'd3:    cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  always_comb begin
    frame_bit = 1'b1;
    if (bit_idx == 4'd0)
      frame_bit = 1'b0;
    else if (bit_idx <= 4'd8)
      frame_bit = cur_char[bit_idx[2:0] - 3'd1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ready      <= 1'b1;
      tx         <= 1'b1;
      dropped    <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      char_idx   <= '0;
      conv_cnt   <= '0;
      last_frame <= 1'b0;
      dd         <= '0;
    end else begin
      if (result_valid && !ready)
        dropped <= 1'b1;

      case (state)
        IDLE: begin
          if (result_valid) begin
            dd       <= {12'd0, result};
            conv_cnt <= '0;
            ready    <= 1'b0;
            state    <= CONVERT;
          end
        end

        CONVERT: begin
          dd       <= dd_next;
          conv_cnt <= conv_cnt + 3'd1;
          if (conv_cnt == 3'd7) begin
            conv_cnt <= '0;
            char_idx <= first_idx;
            bit_idx  <= '0;
            // Preloading the wrap value makes the next edge drive the start bit.
            baud_cnt <= BAUD_MAX;
            state    <= SEND;
          end
        end

        SEND: begin
          if (baud_cnt == BAUD_MAX) begin
            baud_cnt <= '0;
            if (last_frame) begin
              last_frame <= 1'b0;
              bit_idx    <= '0;
              char_idx   <= '0;
              tx         <= 1'b1;
              ready      <= 1'b1;
              state      <= IDLE;
            end else begin
              tx <= frame_bit;
              if (bit_idx == 4'd9) begin
                bit_idx <= '0;
                if (char_idx == 3'd4)
                  last_frame <= 1'b1;
                else
                  char_idx <= char_idx + 3'd1;
              end else begin
                bit_idx <= bit_idx + 4'd1;
              end
            end
          end else begin
            baud_cnt <= baud_cnt + 10'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
